// File: rtl/ucsbece154b_perf_counters.sv
// Retire-stage performance counter bank: cycles, retired, branches, correct branches, jumps, correct jumps.
// Define PERF_COUNTERS_SATURATE_EN to make counters saturate instead of wrapping.
module ucsbece154b_perf_counters #(
  parameter int LANES = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [LANES-1:0] retire_valid_i,
  input  logic [LANES-1:0] retire_branch_i,
  input  logic [LANES-1:0] retire_jump_i,
  input  logic [LANES-1:0] retire_mispred_i,
  input  logic             rd_en_i,
  input  logic [2:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [5:0]       ovf_o
);

  localparam int NCNT = 6;
  localparam int PC_W = 4;

  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [LANES-1:0] q_ret, q_br, q_jp, q_brc, q_jpc;
  logic [PC_W-1:0]  pc  [NCNT];
  logic [CNT_W-1:0] inc [NCNT];
  logic [CNT_W:0]   sum [NCNT];

  // A lane flagged as both branch and jump counts as a jump only.
  assign q_ret = retire_valid_i;
  assign q_br  = retire_valid_i & retire_branch_i & ~retire_jump_i;
  assign q_jp  = retire_valid_i & retire_jump_i;
  assign q_brc = q_br & ~retire_mispred_i;
  assign q_jpc = q_jp & ~retire_mispred_i;

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      pc[i] = '0;
    end
    pc[0] = PC_W'(1);
    for (int k = 0; k < LANES; k++) begin
      pc[1] = pc[1] + PC_W'(q_ret[k]);
      pc[2] = pc[2] + PC_W'(q_br[k]);
      pc[3] = pc[3] + PC_W'(q_brc[k]);
      pc[4] = pc[4] + PC_W'(q_jp[k]);
      pc[5] = pc[5] + PC_W'(q_jpc[k]);
    end
    for (int i = 0; i < NCNT; i++) begin
      inc[i] = CNT_W'(pc[i]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NCNT; i++) begin
      sum[i]   = {1'b0, cnt_q[i]} + {1'b0, inc[i]};
      cnt_d[i] = cnt_q[i];
    end
    if (clear_i) begin
      ovf_d = '0;
      for (int i = 0; i < NCNT; i++) begin
        cnt_d[i] = '0;
      end
    end else if (en_i) begin
      for (int i = 0; i < NCNT; i++) begin
        ovf_d[i] = ovf_q[i] | sum[i][CNT_W];
`ifdef PERF_COUNTERS_SATURATE_EN
        cnt_d[i] = sum[i][CNT_W] ? {CNT_W{1'b1}} : sum[i][CNT_W-1:0];
`else
        cnt_d[i] = sum[i][CNT_W-1:0];
`endif
      end
    end
  end

  // Read returns the value held before this edge's update or clear.
  always_comb begin
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_data_q;
    if (rd_en_i) begin
      case (rd_sel_i)
        3'd0:    rd_data_d = cnt_q[0];
        3'd1:    rd_data_d = cnt_q[1];
        3'd2:    rd_data_d = cnt_q[2];
        3'd3:    rd_data_d = cnt_q[3];
        3'd4:    rd_data_d = cnt_q[4];
        3'd5:    rd_data_d = cnt_q[5];
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_q;

endmodule
